// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
//   Read-side controller of an asynchronous FIFO, running entirely in the rclk
//   domain directly downstream of the SRAM port-1 read interface.
//   - Synchronises the writer's Gray pointer and converts it to binary.
//   - Issues SRAM reads while the local buffer has room.
//   - Absorbs the SRAM's one-cycle read latency in a 2-entry output buffer.
//   - Presents a valid/ready stream at one word per cycle.
//   - Returns the committed read pointer, in Gray, to the write domain.
//
// Ports
//   rclk             in   read clock, the only clock
//   rrst             in   synchronous reset, active-high
//   wptr_gray_async  in   write pointer (Gray) from the wclk domain
//   rptr_gray        out  committed read pointer (Gray), registered
//   sram_csb         out  SRAM port-1 chip select, active-low
//   sram_raddr       out  SRAM port-1 address
//   sram_rdata       in   SRAM port-1 read data, valid the cycle after issue
//   dout             out  head word of the output buffer
//   dout_valid       out  dout holds a valid word
//   dout_ready       in   consumer accepts dout
//   empty            out  nothing buffered, in flight, or waiting to be issued
// -----------------------------------------------------------------------------
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int PTR_WIDTH   = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [PTR_WIDTH:0]    wptr_gray_async,
  output logic [PTR_WIDTH:0]    rptr_gray,
  output logic                  sram_csb,
  output logic [PTR_WIDTH-1:0]  sram_raddr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  empty
);

  typedef logic [PTR_WIDTH:0]  ptr_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_WIDTH] = g[PTR_WIDTH];
    for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // ---------------------------------------------------------------------------
  // Write-pointer synchroniser
  // ---------------------------------------------------------------------------
  ptr_t sync_q [SYNC_STAGES];
  ptr_t wbin;

  // NOTE: every clocked process uses non-blocking assignments so that all
  // registers sample the values from before the edge, whatever the order in
  // which the simulator evaluates them.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= wptr_gray_async;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wbin = gray2bin(sync_q[SYNC_STAGES-1]);

  // ---------------------------------------------------------------------------
  // Read state
  //   ibin     : next address to issue to the SRAM
  //   cbin     : words whose data has landed in the buffer (slots released)
  //   inflight : a read was issued last cycle; sram_rdata is valid now
  // ---------------------------------------------------------------------------
  ptr_t        ibin;
  ptr_t        cbin;
  ptr_t        cbin_next;
  logic        inflight;
  logic [1:0]  buf_cnt;
  logic [1:0]  buf_cnt_next;
  word_t       buf_mem [2];
  logic        wr_sel;
  logic        rd_sel;

  logic        avail;
  logic        pop;
  logic        issue;
  logic [2:0]  occ_after_pop;

  assign dout_valid = (buf_cnt != 2'd0);
  assign dout       = buf_mem[rd_sel];
  assign pop        = dout_valid & dout_ready;
  assign avail      = (wbin != ibin);

  // Occupancy the buffer would have if this cycle's pop and the pending
  // capture both complete; a new read only goes out if it will fit.
  assign occ_after_pop = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};

  // Reset gates the issue so no SRAM read is started while rrst is high,
  // even before the first reset edge has cleared the pointers.
  assign issue      = ~rrst & avail & (occ_after_pop < 3'd2);
  assign sram_csb   = ~issue;
  assign sram_raddr = ibin[PTR_WIDTH-1:0];

  // Built from registered state only, so dout_ready never reaches empty.
  assign empty = (wbin == ibin) & ~inflight & (buf_cnt == 2'd0);

  // The capture happens on the edge after the issue, i.e. whenever inflight.
  assign cbin_next    = cbin + ptr_t'(inflight);
  assign buf_cnt_next = 2'(buf_cnt + {1'b0, inflight} - {1'b0, pop});

  always_ff @(posedge rclk) begin
    if (rrst) begin
      ibin      <= '0;
      cbin      <= '0;
      inflight  <= 1'b0;
      rptr_gray <= '0;
      buf_cnt   <= 2'd0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      // NOTE: the two buffer words are cleared on reset (unlike a large RAM)
      // because dout is read straight from them and must be 0 after reset.
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
    end else begin
      inflight <= issue;
      if (issue) ibin <= ibin + ptr_t'(1);

      if (inflight) begin
        buf_mem[wr_sel] <= sram_rdata;
        wr_sel          <= ~wr_sel;
      end
      if (pop) rd_sel <= ~rd_sel;
      buf_cnt <= buf_cnt_next;

      // A slot goes back to the writer only once its data is held locally.
      cbin      <= cbin_next;
      rptr_gray <= bin2gray(cbin_next);
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_ctrl
//   Directed bench for fifo_rd_ctrl. A behavioural SRAM returns word_at(addr)
//   one cycle after a read; the writer side is modelled by stepping a binary
//   write pointer by at most one per cycle and presenting it in Gray.
// -----------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

  localparam int DW = 8;
  localparam int PW = 10;

  logic          rclk = 1'b0;
  logic          rrst;
  logic [PW:0]   wptr_gray_async;
  logic [PW:0]   rptr_gray;
  logic          sram_csb;
  logic [PW-1:0] sram_raddr;
  logic [DW-1:0] sram_rdata = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          empty;

  int errors = 0;
  int checks = 0;
  int wb_int = 0;

  always #5 rclk = ~rclk;

  fifo_rd_ctrl #(.DATA_WIDTH(DW), .PTR_WIDTH(PW), .SYNC_STAGES(2)) dut (
    .rclk            (rclk),
    .rrst            (rrst),
    .wptr_gray_async (wptr_gray_async),
    .rptr_gray       (rptr_gray),
    .sram_csb        (sram_csb),
    .sram_raddr      (sram_raddr),
    .sram_rdata      (sram_rdata),
    .dout            (dout),
    .dout_valid      (dout_valid),
    .dout_ready      (dout_ready),
    .empty           (empty)
  );

  // Memory contents: a fixed pattern with distinct neighbouring words.
  function automatic logic [DW-1:0] word_at(input int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  function automatic logic [PW:0] gray(input int n);
    logic [PW:0] b;
    b = 11'(n);
    return b ^ (b >> 1);
  endfunction

  // Behavioural SRAM read port: one-cycle latency, holds data otherwise.
  always @(posedge rclk) begin
    if (sram_csb === 1'b0) sram_rdata <= word_at(int'(sram_raddr));
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic set_wb(input int n);
    wb_int          = n;
    wptr_gray_async = gray(n);
  endtask

  task automatic apply_reset();
    rrst       = 1'b1;
    dout_ready = 1'b0;
    set_wb(0);
    repeat (3) tick();
    rrst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rrst       = 1'b1;
    dout_ready = 1'b0;
    wptr_gray_async = 11'd5;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      checks++;
      if (sram_csb !== 1'b1) begin
        errors++;
        $display("FAIL reset_csb cycle %0d: got %b want 1", c, sram_csb);
      end
    end
    checks++;
    if (rptr_gray !== '0) begin
      errors++; $display("FAIL reset_rptr: got %h want 0", rptr_gray);
    end
    checks++;
    if (sram_raddr !== '0) begin
      errors++; $display("FAIL reset_raddr: got %0d want 0", sram_raddr);
    end
    checks++;
    if (dout !== '0) begin
      errors++; $display("FAIL reset_dout: got %h want 0", dout);
    end
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", dout_valid);
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL reset_empty: got %b want 1", empty);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_word();
    apply_reset();
    dout_ready = 1'b1;
    set_wb(1);            // Gray 0 -> 1 before edge 0
    tick();               // edge 0
    tick();               // edge 1
    #1;
    checks++;
    if (sram_csb !== 1'b0 || sram_raddr !== '0) begin
      errors++;
      $display("FAIL single_issue: got csb=%b raddr=%0d want csb=0 raddr=0", sram_csb, sram_raddr);
    end
    tick();               // edge 2
    tick();               // edge 3
    #1;
    checks++;
    if (dout_valid !== 1'b1 || dout !== word_at(0)) begin
      errors++;
      $display("FAIL single_data: got valid=%b dout=%h want valid=1 dout=%h", dout_valid, dout, word_at(0));
    end
    checks++;
    if (rptr_gray !== gray(1)) begin
      errors++; $display("FAIL single_rptr: got %h want %h", rptr_gray, gray(1));
    end
    tick();               // edge 4, word popped
    #1;
    checks++;
    if (empty !== 1'b1 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_empty: got empty=%b valid=%b want empty=1 valid=0", empty, dout_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    int n_iss;
    int iss_addr [4];
    int popped;
    int gaps;
    bit seen_valid;
    n_iss      = 0;
    seen_valid = 1'b0;
    apply_reset();
    dout_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) set_wb(c + 1);
      tick();
      #1;
      if (sram_csb === 1'b0) begin
        if (n_iss < 4) iss_addr[n_iss] = int'(sram_raddr);
        n_iss++;
      end
      if (dout_valid === 1'b1) begin
        seen_valid = 1'b1;
        checks++;
        if (dout !== word_at(0)) begin
          errors++; $display("FAIL bp_hold cycle %0d: got %h want %h", c, dout, word_at(0));
        end
      end
    end
    checks++;
    if (!seen_valid) begin
      errors++; $display("FAIL bp_valid: got no valid word want dout_valid=1");
    end
    checks++;
    if (n_iss !== 2) begin
      errors++; $display("FAIL bp_issue_count: got %0d want 2", n_iss);
    end else begin
      checks++;
      if (iss_addr[0] !== 0 || iss_addr[1] !== 1) begin
        errors++;
        $display("FAIL bp_issue_addr: got %0d,%0d want 0,1", iss_addr[0], iss_addr[1]);
      end
    end

    dout_ready = 1'b1;
    #1;
    popped = 0;
    gaps   = 0;
    for (int c = 0; c < 10 && popped < 4; c++) begin
      if (dout_valid === 1'b1) begin
        checks++;
        if (dout !== word_at(popped)) begin
          errors++; $display("FAIL bp_drain word %0d: got %h want %h", popped, dout, word_at(popped));
        end
        popped++;
      end else begin
        gaps++;
      end
      tick();
      #1;
    end
    checks++;
    if (popped !== 4 || gaps !== 0) begin
      errors++; $display("FAIL bp_drain_flow: got popped=%0d gaps=%0d want popped=4 gaps=0", popped, gaps);
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL bp_empty: got %b want 1", empty);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_streaming();
    int n_iss, iss_first, iss_last;
    int n_v, v_first, v_last, bad;
    n_iss = 0; iss_first = 0; iss_last = 0;
    n_v = 0; v_first = 0; v_last = 0; bad = 0;
    apply_reset();
    dout_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c < 16) set_wb(c + 1);
      tick();
      #1;
      if (sram_csb === 1'b0) begin
        if (n_iss == 0) iss_first = c;
        iss_last = c;
        n_iss++;
      end
      if (dout_valid === 1'b1) begin
        if (n_v == 0) v_first = c;
        v_last = c;
        if (dout !== word_at(n_v)) bad++;
        n_v++;
      end
    end
    checks++;
    if (n_iss !== 16 || iss_last - iss_first !== 15) begin
      errors++;
      $display("FAIL stream_issue: got %0d issues over %0d cycles want 16 over 16",
               n_iss, iss_last - iss_first + 1);
    end
    checks++;
    if (n_v !== 16 || v_last - v_first !== 15) begin
      errors++;
      $display("FAIL stream_valid: got %0d words over %0d cycles want 16 over 16",
               n_v, v_last - v_first + 1);
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL stream_data: got %0d wrong words want 0", bad);
    end
    checks++;
    if (rptr_gray !== 11'd24) begin
      errors++; $display("FAIL stream_rptr: got %h want 018", rptr_gray);
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL stream_empty: got %b want 1", empty);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wrap();
    int popped;
    int n_iss;
    int iss_addr [4];
    int exp_addr [4];
    int n_v;
    bit done;
    bit seen_600;
    exp_addr = '{1022, 1023, 0, 1};
    popped = 0; done = 1'b0; n_iss = 0; n_v = 0; seen_600 = 1'b0;
    apply_reset();
    dout_ready = 1'b1;
    // Move both pointers to 1022 by streaming 1022 words through.
    for (int c = 0; c < 1100 && !done; c++) begin
      if (wb_int < 1022) set_wb(wb_int + 1);
      tick();
      #1;
      if (dout_valid === 1'b1) popped++;
      if (popped == 1022 && empty === 1'b1) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL wrap_preset: got %0d words drained want 1022 and empty", popped);
    end
    checks++;
    if (rptr_gray !== gray(1022)) begin
      errors++; $display("FAIL wrap_preset_rptr: got %h want %h", rptr_gray, gray(1022));
    end

    for (int c = 0; c < 16; c++) begin
      if (wb_int < 1026) set_wb(wb_int + 1);
      tick();
      #1;
      if (sram_csb === 1'b0) begin
        if (n_iss < 4) iss_addr[n_iss] = int'(sram_raddr);
        n_iss++;
      end
      if (dout_valid === 1'b1) begin
        checks++;
        if (n_v >= 4 || dout !== word_at(exp_addr[n_v < 4 ? n_v : 0])) begin
          errors++; $display("FAIL wrap_data word %0d: got %h", n_v, dout);
        end
        n_v++;
      end
      if (rptr_gray === 11'h600) seen_600 = 1'b1;
    end
    checks++;
    if (n_iss !== 4) begin
      errors++; $display("FAIL wrap_issue_count: got %0d want 4", n_iss);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (iss_addr[k] !== exp_addr[k]) begin
          errors++; $display("FAIL wrap_addr %0d: got %0d want %0d", k, iss_addr[k], exp_addr[k]);
        end
      end
    end
    checks++;
    if (!seen_600) begin
      errors++; $display("FAIL wrap_rptr_600: got no 600 want rptr_gray=600 observed");
    end
    checks++;
    if (rptr_gray !== 11'h603) begin
      errors++; $display("FAIL wrap_rptr_end: got %h want 603", rptr_gray);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_midstream();
    bit got_valid;
    int stale;
    got_valid = 1'b0;
    stale     = 0;
    apply_reset();
    dout_ready = 1'b0;
    for (int c = 0; c < 10 && !got_valid; c++) begin
      if (c < 4) set_wb(c + 1);
      tick();
      #1;
      if (dout_valid === 1'b1) got_valid = 1'b1;
    end
    checks++;
    if (!got_valid) begin
      errors++; $display("FAIL mid_setup: got no valid word want dout_valid=1");
    end
    // One word held, one in flight: the buffer is full, so nothing issues.
    checks++;
    if (sram_csb !== 1'b1) begin
      errors++; $display("FAIL mid_full: got csb=%b want 1", sram_csb);
    end

    rrst = 1'b1;
    set_wb(0);
    tick();
    #1;
    checks++;
    if (dout_valid !== 1'b0 || empty !== 1'b1 || rptr_gray !== '0 || dout !== '0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%b empty=%b rptr=%h dout=%h want 0,1,000,00",
               dout_valid, empty, rptr_gray, dout);
    end
    rrst       = 1'b0;
    dout_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      #1;
      if (dout_valid !== 1'b0 || sram_csb !== 1'b1) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++; $display("FAIL mid_stale: got %0d cycles with activity want 0", stale);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rrst            = 1'b1;
    dout_ready      = 1'b0;
    wptr_gray_async = '0;
    test_reset();
    test_single_word();
    test_backpressure();
    test_streaming();
    test_wrap();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
